// File: rtl/alu_sequencer.sv
// Program sequencer feeding the ALU: fetches 13-bit instruction words and issues each
// as SETUP / ISSUE / HOLD so select/data are stable around a single-cycle perform pulse.
module alu_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [12:0]   prog_wdata,
    input  logic          run,
    input  logic          step,
    input  logic          restart,
    output logic [7:0]    alu_data,
    output logic [3:0]    alu_select,
    output logic          alu_perform,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t        state_reg;
    logic [12:0]   mem [DEPTH];
    logic [AW-1:0] pc_reg;
    logic [AW-1:0] pc_inc;
    logic [7:0]    data_reg;
    logic [3:0]    select_reg;
    logic          perform_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [12:0]   cur_word;
    logic [12:0]   next_word;

    // Fetch must be visible in the same cycle the decision is made, so the
    // program store is read asynchronously; pc_inc wraps naturally at DEPTH.
    assign pc_inc    = pc_reg + AW'(1);
    assign cur_word  = mem[pc_reg];
    assign next_word = mem[pc_inc];

    always_ff @(posedge clk) begin
        if (prog_we && !busy_reg) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            pc_reg      <= '0;
            data_reg    <= '0;
            select_reg  <= '0;
            perform_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            perform_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (restart) begin
                        pc_reg <= '0;
                    end else if (run || step) begin
                        if (cur_word[12]) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            select_reg <= cur_word[11:8];
                            data_reg   <= cur_word[7:0];
                            busy_reg   <= 1'b1;
                            state_reg  <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    perform_reg <= 1'b1;
                    state_reg   <= S_ISSUE;
                end
                S_ISSUE: begin
                    state_reg <= S_HOLD;
                end
                S_HOLD: begin
                    pc_reg <= pc_inc;
                    if (run) begin
                        if (next_word[12]) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            select_reg <= next_word[11:8];
                            data_reg   <= next_word[7:0];
                            state_reg  <= S_SETUP;
                        end
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                S_DONE: begin
                    // Only restart leaves DONE; run and step are deliberately ignored.
                    if (restart) begin
                        pc_reg    <= '0;
                        done_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_data    = data_reg;
    assign alu_select  = select_reg;
    assign alu_perform = perform_reg;
    assign pc          = pc_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Program sequencer sitting directly upstream of the ALU. It holds a small writable program of ALU instructions and drives the ALU's data, select and perform inputs. Each instruction is issued with select/data stable for one cycle before, during and after a single-cycle perform pulse, so the ALU's edge/select-sensitive logic sees clean operands. Supports free-running execution, single-step, restart and an in-program halt marker.

Parameters:
DEPTH, 16, number of program words
AW, 4, program address width; DEPTH = 2**AW

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
prog_we  input  1  program write enable
prog_addr  input  AW  program write address
prog_wdata  input  13  instruction word: [12] halt, [11:8] select, [7:0] data
run  input  1  level; execute continuously while high
step  input  1  pulse; execute one instruction from IDLE
restart  input  1  pulse; return pc to 0, clear done
alu_data  output  8  to ALU data
alu_select  output  4  to ALU select
alu_perform  output  1  to ALU perform, one-cycle pulse
pc  output  AW  address of current/next instruction
busy  output  1  high in SETUP, ISSUE, HOLD
done  output  1  high in DONE

Behaviour:
- Reset (reset==0 at clk edge): state IDLE, pc=0, alu_data=0, alu_select=0, alu_perform=0, busy=0, done=0. Program memory is not reset; reset mid-instruction aborts immediately, perform forced 0 that cycle.
- States: IDLE, SETUP, ISSUE, HOLD, DONE. Program memory is DEPTH x 13 registers.
- IDLE: if run or step -> read mem[pc]; if bit12 set -> DONE (no perform issued, pc unchanged); else latch select/data onto alu_select/alu_data, -> SETUP. run and step together = run. Neither -> stay.
- SETUP (1 cycle): perform=0, outputs stable -> ISSUE.
- ISSUE (1 cycle): alu_perform=1 -> HOLD.
- HOLD (1 cycle): perform=0, select/data held; pc <= pc+1 (wraps DEPTH-1 -> 0). If run still high: read mem[pc+1] (wrapped); halt bit -> DONE, else latch and -> SETUP. If run low -> IDLE.
- Throughput: 3 cycles per instruction while running; run asserted in IDLE at edge t -> perform high during cycle t+2.
- step while busy ignored; run deassert mid-instruction completes current instruction through HOLD then IDLE.
- DONE: done=1, outputs hold last values; run/step ignored. restart -> pc=0, done=0, IDLE.
- restart in IDLE: pc=0. restart while busy ignored.
- prog_we honoured only when busy==0 (IDLE/DONE): mem[prog_addr] <= prog_wdata; ignored while busy. Write to mem[pc] in IDLE takes effect on next fetch.
- alu_data/alu_select change only on fetch (IDLE->SETUP, HOLD->SETUP); never while perform is high or in the cycle after.

Test Plan:
- Reset: hold reset=0 two cycles mid-run -> all outputs 0, state IDLE, pc=0, no perform pulse.
- Load mem0=0_1111_00000101, mem1=0_1110_00000000, mem2=0_1111_00000011, mem3=0_0000_00000000, mem4=1_0000_00000000; pulse run high continuously -> four perform pulses 3 cycles apart with (select,data)=(F,05),(E,00),(F,03),(0,00); done=1, pc=4; select/data stable one cycle each side of every pulse.
- Step: same program after restart, pulse step once -> exactly one perform with (F,05), pc=1, IDLE; step asserted during busy ignored.
- Wrap: DEPTH=16, no halt words, mem15=0_1011_00000000; run from pc=15 -> perform (B,00), pc wraps to 0, execution continues from mem0.
- Write lockout: prog_we with addr=2 while busy -> mem2 unchanged; same write in IDLE -> new value issued on next fetch.
- run dropped during ISSUE -> pulse completes, HOLD, pc increments, IDLE, no further perform; restart in DONE -> pc=0, done=0.
